// File: rtl/sipo_pkg.sv
// -----------------------------------------------------------------------------
// sipo_pkg
//
// Shared definitions for the serial link receiver (and its matching
// transmitter): the default word width and the receiver state encodings.
//
// Contents:
//   SIPO_WIDTH   default data bits per word; must match the transmitter
//   rx_state_t   RX_DATA = 1'b0 : collecting data bits
//                RX_PAR  = 1'b1 : parity bit pending (SIPO_PARITY_EN builds)
// -----------------------------------------------------------------------------
package sipo_pkg;

  localparam int SIPO_WIDTH = 4;

  typedef enum logic {
    RX_DATA = 1'b0,
    RX_PAR  = 1'b1
  } rx_state_t;

endpackage

// File: rtl/sipo_shreg.sv
// -----------------------------------------------------------------------------
// sipo_shreg
//
// Serial-to-parallel shift register plus bit counter for sipo_rx. Bits
// arrive MSB first, one per clock in which sin_valid is high. Only WIDTH-1
// earlier bits are stored. The final bit of a word is taken straight from
// sin, so the finished word is on `word` during the same cycle that
// samples its last bit.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   clr        in   synchronous resync: drop the partial word and zero the
//                   counter; takes priority over sin_valid
//   sin_valid  in   shift sin in on this edge (the parent gates this off
//                   while a parity bit is expected)
//   sin        in   serial data bit
//   word       out  WIDTH  {stored bits, sin}: the full word when last=1
//   last       out  this edge samples the final data bit of a word
// -----------------------------------------------------------------------------
module sipo_shreg
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             sin_valid,
  input  logic             sin,
  output logic [WIDTH-1:0] word,
  output logic             last
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [WIDTH-2:0] sr;
  logic [CW-1:0]    cnt;
  logic             at_last;

  assign word    = {sr, sin};
  assign at_last = (cnt == CW'(WIDTH - 1));
  assign last    = sin_valid && !clr && at_last;

  // NOTE: clocked state is always assigned with <= so every flop samples
  // the pre-edge values of the others; blocking '=' here would create
  // order-dependent races in simulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr  <= '0;
      cnt <= '0;
    end else if (clr) begin
      sr  <= '0;
      cnt <= '0;
    end else if (sin_valid) begin
      sr  <= word[WIDTH-2:0];
      // Explicit wrap, so a WIDTH that is not a power of two still works.
      cnt <= at_last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sipo_rx.sv
// -----------------------------------------------------------------------------
// sipo_rx
//
// Serial-in, parallel-out word receiver: the far end of the shift-register
// serial link. It assembles WIDTH-bit words, MSB first, from bits qualified
// by sin_valid. Each finished word goes to a holding register that is
// offered downstream on a valid/ready handshake. A finished word that
// arrives while the holding register is still full and not being accepted
// is dropped and sets the sticky overrun flag.
//
// Build option:
//   SIPO_PARITY_EN  when defined, each word is followed by one even-parity
//                   bit (also qualified by sin_valid). The word is delivered
//                   on the parity edge, and parity_err is loaded with it:
//                   parity_err = ^data ^ parity_bit. When undefined, there is
//                   no parity bit and no parity_err port.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   asynchronous, active-high reset
//   clr         in   synchronous resync: drop the partial or pending word,
//                    return to RX_DATA, clear overrun. Holding register,
//                    out_valid and parity_err are left alone.
//   sin_valid   in   qualifies sin this cycle
//   sin         in   serial bit, MSB of word first
//   out         out  WIDTH  holding-register word
//   out_valid   out  out holds an unconsumed word
//   out_ready   in   consumer takes the word when out_valid && out_ready
//   busy        out  a word is partly received (registered)
//   overrun     out  sticky: a completed word was dropped
//   parity_err  out  (SIPO_PARITY_EN only) parity failure for the word in out
// -----------------------------------------------------------------------------
module sipo_rx
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             sin_valid,
  input  logic             sin,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun
`ifdef SIPO_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  rx_state_t        state;
  rx_state_t        state_n;

  logic             shift_valid;  // sin_valid gated to data-bit cycles
  logic [WIDTH-1:0] word;         // word being finished this cycle
  logic             last;         // this edge samples the last data bit
  logic             complete;     // a word is handed to the holding stage
  logic [WIDTH-1:0] cword;        // the word being handed over
  logic             busy_n;

`ifdef SIPO_PARITY_EN
  logic [WIDTH-1:0] pend_word;    // data waiting for its parity bit
  logic             perr;         // parity result for cword
`endif

  sipo_shreg #(
    .WIDTH (WIDTH)
  ) u_shreg (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .sin_valid (shift_valid),
    .sin       (sin),
    .word      (word),
    .last      (last)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RX_DATA;
    end else begin
      state <= state_n;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. Without parity the machine never leaves RX_DATA.
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven in an always_comb gets a default on its first
  // line; any path that leaves one unassigned would infer a latch.
  always_comb begin
    state_n = state;
    if (clr) begin
      state_n = RX_DATA;
    end else begin
      case (state)
        RX_DATA: begin
`ifdef SIPO_PARITY_EN
          if (last) state_n = RX_PAR;
`endif
        end
        RX_PAR: begin
          if (sin_valid) state_n = RX_DATA;
        end
        default: state_n = RX_DATA;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. These are the shift qualification, word completion,
  // the word and parity result handed over, and the next busy value.
  // ---------------------------------------------------------------------------
  always_comb begin
    shift_valid = sin_valid && (state == RX_DATA);
    complete    = 1'b0;
    cword       = word;
    busy_n      = busy;
`ifdef SIPO_PARITY_EN
    perr        = 1'b0;
`endif

    if (clr) begin
      // A bit arriving together with clr is ignored, and so is any word it
      // would have finished.
      busy_n = 1'b0;
    end else if (shift_valid) begin
`ifdef SIPO_PARITY_EN
      // The word stays in progress until its parity bit arrives.
      busy_n = 1'b1;
`else
      complete = last;
      busy_n   = !last;
`endif
    end
`ifdef SIPO_PARITY_EN
    else if (state == RX_PAR && sin_valid) begin
      complete = 1'b1;
      cword    = pend_word;
      perr     = (^pend_word) ^ sin;
      busy_n   = 1'b0;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Holding register, handshake and sticky overrun
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
`ifdef SIPO_PARITY_EN
      parity_err <= 1'b0;
      pend_word  <= '0;
`endif
    end else begin
      busy <= busy_n;

      if (complete) begin
        // A word accepted on this edge makes room for the new one, so
        // back-to-back words with out_ready held high never overrun.
        if (!out_valid || out_ready) begin
          out       <= cword;
          out_valid <= 1'b1;
`ifdef SIPO_PARITY_EN
          parity_err <= perr;
`endif
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      // complete is never set together with clr, so this cannot hide a
      // new overrun.
      if (clr) overrun <= 1'b0;

`ifdef SIPO_PARITY_EN
      if (last) pend_word <= word;
`endif
    end
  end

endmodule

// File: tb/tb_sipo_rx.sv
// -----------------------------------------------------------------------------
// tb_sipo_rx
//
// Directed bench for sipo_rx (WIDTH = 4). Stimulus tasks push each word
// expected downstream into a scoreboard queue. A monitor pops the queue and
// compares whenever the DUT offers a word that is being accepted. Status
// outputs (busy, out_valid, overrun, out) are checked inline at known
// points, with values worked out by hand.
// With SIPO_PARITY_EN defined, every word carries a correct parity bit,
// plus one word that has a wrong parity bit.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sipo_rx;
  import sipo_pkg::*;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] word;
    logic         perr;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         clr;
  logic         sin_valid;
  logic         sin;
  logic [W-1:0] out;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         overrun;
`ifdef SIPO_PARITY_EN
  logic         parity_err;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  sipo_rx #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .sin_valid (sin_valid),
    .sin       (sin),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .overrun   (overrun)
`ifdef SIPO_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic [W-1:0] w, input logic pe);
    exp_t e;
    e.word = w;
    e.perr = pe;
    sb.push_back(e);
  endtask

  // One qualified bit, sampled on the next rising edge; returns #1 after it.
  task automatic send_bit(input logic b);
    sin_valid = 1'b1;
    sin       = b;
    @(posedge clk);
    #1;
    sin_valid = 1'b0;
    sin       = 1'b0;
  endtask

  task automatic send_data(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  // Data bits, plus a correct even-parity bit when parity is built in.
  task automatic send_word(input logic [W-1:0] w);
    send_data(w);
`ifdef SIPO_PARITY_EN
    send_bit(^w);
`endif
  endtask

  // Let the consumer take everything queued, within a bounded wait.
  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("drain_empty", sb.size(), 0);
    check("drain_out_valid", out_valid, 1'b0);
  endtask

  // Scoreboard monitor: a word is consumed on the edge after this sample.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_word", out, 32'hdead);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_word", out, e.word);
`ifdef SIPO_PARITY_EN
        check("sb_parity_err", parity_err, e.perr);
`endif
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    clr       = 1'b0;
    sin_valid = 1'b0;
    sin       = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check("rst_out", out, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // 1) Plain word 4'hB, with latency and busy checks.
    expect_word(4'hB, 1'b0);
    send_bit(1'b1);
    check("t1_busy_after_first", busy, 1);
    send_bit(1'b0);
    send_bit(1'b1);
    check("t1_no_early_valid", out_valid, 0);
    send_bit(1'b1);
`ifdef SIPO_PARITY_EN
    check("t1_wait_parity", out_valid, 0);
    send_bit(1'b1);
`endif
    check("t1_out_valid", out_valid, 1);
    check("t1_out", out, 4'hB);
    check("t1_busy_done", busy, 0);
    drain();

    // 2) Same word with a 3-cycle gap between bits 2 and 3.
    expect_word(4'hB, 1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("t2_gap_busy", busy, 1);
      check("t2_gap_no_valid", out_valid, 0);
    end
    send_bit(1'b1);
    send_bit(1'b1);
`ifdef SIPO_PARITY_EN
    send_bit(1'b1);
`endif
    check("t2_out", out, 4'hB);
    drain();

    // 3) Back-to-back 4'hB, 4'h6 with out_ready high: no overrun.
    expect_word(4'hB, 1'b0);
    expect_word(4'h6, 1'b0);
    out_ready = 1'b1;
    send_word(4'hB);
    send_word(4'h6);
    drain();
    check("t3_no_overrun", overrun, 0);

    // 4) Consumer stalled: the second word is dropped, and clr clears
    //    overrun only.
    expect_word(4'hB, 1'b0);
    send_word(4'hB);
    check("t4_overrun_before", overrun, 0);
    send_word(4'h6);
    check("t4_out_held", out, 4'hB);
    check("t4_overrun_set", overrun, 1);
    @(posedge clk);
    #1;
    check("t4_overrun_sticky", overrun, 1);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    check("t4_clr_overrun", overrun, 0);
    check("t4_clr_out", out, 4'hB);
    check("t4_clr_out_valid", out_valid, 1);
    drain();

    // 5) Two bits, then clr while a bit is offered, then 4'h5.
    send_bit(1'b1);
    send_bit(1'b0);
    clr       = 1'b1;
    sin_valid = 1'b1;
    sin       = 1'b1;
    @(posedge clk);
    #1;
    clr       = 1'b0;
    sin_valid = 1'b0;
    sin       = 1'b0;
    check("t5_clr_busy", busy, 0);
    expect_word(4'h5, 1'b0);
    send_word(4'h5);
    check("t5_out", out, 4'h5);
    drain();

    // 6) Held word, overrun and a partial word, all wiped by async reset.
    expect_word(4'hB, 1'b0);
    send_word(4'hB);
    send_word(4'h6);
    send_bit(1'b1);
    send_bit(1'b0);
    check("t6_pre_busy", busy, 1);
    check("t6_pre_overrun", overrun, 1);
    rst = 1'b1;
    #1;
    sb.delete();
    check("t6_rst_out", out, 0);
    check("t6_rst_out_valid", out_valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_overrun", overrun, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    expect_word(4'h3, 1'b0);
    send_word(4'h3);
    check("t6_after_rst_out", out, 4'h3);
    drain();

`ifdef SIPO_PARITY_EN
    // 7) Parity error: 4'hB (three ones) followed by parity bit 0.
    expect_word(4'hB, 1'b1);
    send_data(4'hB);
    send_bit(1'b0);
    check("t7_out", out, 4'hB);
    check("t7_parity_err", parity_err, 1);
    drain();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sipo_rx.md
# sipo_rx

Serial-in, parallel-out word receiver: the receive end of the 4-bit parallel-in serial-out shift-register link. It accepts one serial bit per qualified clock, MSB first, and assembles WIDTH-bit words with a bit counter. Each completed word goes into a holding register and is offered downstream on a valid/ready handshake, with sticky overrun detection. It sits at the far end of the serial wire, feeding any parallel consumer.

## Interface
- WIDTH, 4, data bits per word (≥2); must match the transmitter word width.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous resync: discard partial word, zero bit counter, clear overrun.
- sin_valid  in  1  qualifies sin this cycle.
- sin  in  1  serial data bit, MSB of word first.
- out  out  WIDTH  holding-register word.
- out_valid  out  1  out holds an unconsumed word.
- out_ready  in  1  consumer accepts word when out_valid && out_ready.
- busy  out  1  partial word in progress (bit counter ≠ 0 or in RX_PAR).
- overrun  out  1  sticky: a completed word was dropped.
- parity_err  out  1  only with SIPO_PARITY_EN; parity result for word in out.

## Operation
- Reset values: out=0, out_valid=0, busy=0, overrun=0, parity_err=0, shift register=0, counter=0, state RX_DATA.
- States: RX_DATA (collecting data bits); RX_PAR (parity bit pending, macro only).
- RX_DATA, sin_valid=1: sr <= {sr[WIDTH-2:0], sin}; cnt <= cnt+1. sin_valid=0: sr, cnt hold (gaps of any length allowed).
- Last data bit (cnt==WIDTH-1 with sin_valid): cnt wraps to 0. Without macro, word {sr[WIDTH-2:0], sin} completes this edge. With macro, go to RX_PAR and latch the word internally.
- Word completion → holding register: if out_valid=0, or out_valid && out_ready this cycle, load out and set out_valid=1. Otherwise keep old word, drop new, set overrun=1.
- Handshake: out_valid && out_ready with no completing word → out_valid=0 next cycle. out stays stable while out_valid=1 and not accepted.
- clr: highest priority below rst. Discards partial word, returns to RX_DATA, clears overrun. A sin bit in the same cycle is ignored. The holding register, out_valid and parity_err are unaffected.
- Reset mid-word: all state discarded immediately (async), no word delivered.

## Timing
- Each bit is sampled on the rising edge where sin_valid=1.
- Latency: out_valid rises on the same edge that samples the last data bit (parity bit with macro) and is visible the following cycle. Minimum word period is WIDTH cycles (WIDTH+1 with macro).
- Back-to-back words with out_ready tied 1 never overrun.
- busy is registered. It is 1 from the edge sampling the first bit until the edge completing the word.
- overrun sets on the dropping edge and holds until clr or rst.

## Configuration
- SIPO_PARITY_EN defined: each word is followed by one even-parity bit, qualified by sin_valid. parity_err = (XOR of data bits) ^ parity_bit. It is loaded together with out and means even parity failed. The word is delivered regardless. clr in RX_PAR discards the pending word.
- Undefined: no RX_PAR state, no parity bit, and no parity_err port.

## Structure
- Shared package/header sipo_pkg holds:
  - state encodings RX_DATA=1'b0, RX_PAR=1'b1;
  - default WIDTH constant, shared with the transmitter.
- Sub-module sipo_shreg: shift register plus bit counter, with ports clk, rst, clr, sin_valid, sin, word, last. Parent sipo_rx owns the FSM, holding register, handshake and overrun.

## Test plan
- Reset, then bits 1,0,1,1 with sin_valid=1 → out=4'hB, out_valid=1 one cycle after 4th bit edge, busy=0.
- Same bits with sin_valid low for 3 cycles between bits 2 and 3 → still 4'hB. No early out_valid.
- Words 4'hB then 4'h6 back-to-back, out_ready=1 → two accepted words, overrun=0.
- out_ready=0, send 4'hB then 4'h6 → out stays 4'hB, overrun=1 after 2nd word. clr → overrun=0, out still 4'hB.
- Two bits, then clr (with sin_valid=1), then 4'h5 → out=4'h5. Repeat with rst asserted mid-word → all outputs 0.
- SIPO_PARITY_EN: 4'hB plus parity 1 → parity_err=0. 4'hB plus parity 0 → parity_err=1, out=4'hB.
